// File: rtl/mem_write_buffer_if.sv
// Bus bundle for the posted-write buffer.
// Carries the cpu-side memory port (write and read request/acknowledge)
// and the adapter-side byte-serial bus port (write and read request/done).
//   slave  : the write buffer's view (cpu requests in, adapter requests out)
//   master : the surrounding cpu + adapter view (directions mirrored)
// RV is the cpu data width (16 or 32); word address is RV-RV/16 bits wide.
interface mem_write_buffer_if #(
  parameter int RV = 32
);
  localparam int AW = RV - RV / 16;
  localparam int MW = RV / 8;

  // cpu side
  logic [AW-1:0] c_waddr;
  logic [MW-1:0] c_wmask;
  logic [RV-1:0] c_wdata;
  logic          c_wdone;
  logic [AW-1:0] c_raddr;
  logic [1:0]    c_rreq;
  logic [RV-1:0] c_rdata;
  logic          c_rdone;
  // adapter side
  logic [AW-1:0] m_waddr;
  logic [MW-1:0] m_wmask;
  logic [RV-1:0] m_wdata;
  logic          m_wdone;
  logic [AW-1:0] m_raddr;
  logic [1:0]    m_rreq;
  logic [RV-1:0] m_rdata;
  logic          m_rdone;

  modport slave (
    input  c_waddr, c_wmask, c_wdata, c_raddr, c_rreq,
    input  m_wdone, m_rdata, m_rdone,
    output c_wdone, c_rdata, c_rdone,
    output m_waddr, m_wmask, m_wdata, m_raddr, m_rreq
  );

  modport master (
    output c_waddr, c_wmask, c_wdata, c_raddr, c_rreq,
    output m_wdone, m_rdata, m_rdone,
    input  c_wdone, c_rdata, c_rdone,
    input  m_waddr, m_wmask, m_wdata, m_raddr, m_rreq
  );
endinterface

// File: rtl/mem_write_buffer.sv
// Posted-write buffer between the vc32 cpu memory port and the byte-serial
// external bus adapter. Cpu writes are acknowledged one cycle after the
// request and queued in a DEPTH-entry circular FIFO; a background engine
// drains them to the adapter. Reads pass straight through but wait while
// any queued write (including the one being drained) targets the same word.
// Ports:
//   clk   : clock
//   rst_n : synchronous active-low reset (shared with the adapter)
//   bus   : mem_write_buffer_if.slave, cpu write/read port + adapter port
//   idle  : registered, queue empty and no adapter transaction in flight
module mem_write_buffer #(
  parameter int RV    = 32,
  parameter int DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  mem_write_buffer_if.slave bus,
  output logic              idle
);
  localparam int AW = RV - RV / 16;
  localparam int MW = RV / 8;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [PW-1:0] PTR_ONE  = PW'(1'b1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1'b1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WR   = 2'd1,
    ST_RD   = 2'd2
  } state_t;

  // queue storage and bookkeeping
  logic [AW-1:0] q_addr_r [DEPTH];
  logic [MW-1:0] q_mask_r [DEPTH];
  logic [RV-1:0] q_data_r [DEPTH];
  logic [DEPTH-1:0] valid_r;
  logic [PW-1:0] head_r;
  logic [PW-1:0] tail_r;
  logic [CW-1:0] count_r;

  state_t state_r;

  // registered outputs
  logic          c_wdone_r;
  logic          c_rdone_r;
  logic [RV-1:0] c_rdata_r;
  logic [AW-1:0] m_waddr_r;
  logic [MW-1:0] m_wmask_r;
  logic [RV-1:0] m_wdata_r;
  logic [AW-1:0] m_raddr_r;
  logic [1:0]    m_rreq_r;
  logic          idle_r;

  // next-state / control
  logic          push_s;
  logic          pop_s;
  logic          hazard_s;
  logic          rd_go_s;
  logic          wr_go_s;
  logic [CW-1:0] count_nx_s;
  state_t        state_nx_s;
  logic          c_rdone_nx_s;
  logic [RV-1:0] c_rdata_nx_s;
  logic [AW-1:0] m_waddr_nx_s;
  logic [MW-1:0] m_wmask_nx_s;
  logic [RV-1:0] m_wdata_nx_s;
  logic [AW-1:0] m_raddr_nx_s;
  logic [1:0]    m_rreq_nx_s;
  logic          idle_nx_s;

  assign bus.c_wdone = c_wdone_r;
  assign bus.c_rdone = c_rdone_r;
  assign bus.c_rdata = c_rdata_r;
  assign bus.m_waddr = m_waddr_r;
  assign bus.m_wmask = m_wmask_r;
  assign bus.m_wdata = m_wdata_r;
  assign bus.m_raddr = m_raddr_r;
  assign bus.m_rreq  = m_rreq_r;
  assign idle        = idle_r;

  // The acknowledge cycle itself never accepts, which forces a one-cycle
  // bubble so a held request is not pushed twice.
  assign push_s = (bus.c_wmask != {MW{1'b0}}) && (count_r < CNT_FULL) && !c_wdone_r;

  // Hazard: any queued entry, including the one currently on the adapter, matches the read word.
  always_comb begin
    hazard_s = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      hazard_s = hazard_s | (valid_r[i] & (q_addr_r[i] == bus.c_raddr));
    end
  end

  // A non-hazard read beats draining; c_rdone_r blocks re-issue of the read just completed.
  assign rd_go_s = (bus.c_rreq != 2'b00) && !hazard_s && !c_rdone_r;
  assign wr_go_s = (count_r != {CW{1'b0}}) && ((bus.c_rreq == 2'b00) || hazard_s);

  // Downstream engine next-state and next registered outputs.
  always_comb begin
    state_nx_s   = state_r;
    pop_s        = 1'b0;
    c_rdone_nx_s = 1'b0;
    c_rdata_nx_s = c_rdata_r;
    m_waddr_nx_s = m_waddr_r;
    m_wmask_nx_s = m_wmask_r;
    m_wdata_nx_s = m_wdata_r;
    m_raddr_nx_s = m_raddr_r;
    m_rreq_nx_s  = m_rreq_r;
    case (state_r)
      ST_IDLE: begin
        if (rd_go_s) begin
          state_nx_s   = ST_RD;
          m_raddr_nx_s = bus.c_raddr;
          m_rreq_nx_s  = bus.c_rreq;
        end else if (wr_go_s) begin
          state_nx_s   = ST_WR;
          m_waddr_nx_s = q_addr_r[head_r];
          m_wmask_nx_s = q_mask_r[head_r];
          m_wdata_nx_s = q_data_r[head_r];
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_WR: begin
        if (bus.m_wdone) begin
          pop_s        = 1'b1;
          m_wmask_nx_s = {MW{1'b0}};
          state_nx_s   = ST_IDLE;
        end else begin
          state_nx_s = ST_WR;
        end
      end
      ST_RD: begin
        if (bus.m_rdone) begin
          c_rdata_nx_s = bus.m_rdata;
          c_rdone_nx_s = 1'b1;
          m_rreq_nx_s  = 2'b00;
          state_nx_s   = ST_IDLE;
        end else begin
          state_nx_s = ST_RD;
        end
      end
      default: begin
        state_nx_s   = ST_IDLE;
        m_wmask_nx_s = {MW{1'b0}};
        m_rreq_nx_s  = 2'b00;
      end
    endcase
  end

  // Occupancy after this edge's push/pop.
  always_comb begin
    case ({push_s, pop_s})
      2'b10:   count_nx_s = count_r + CNT_ONE;
      2'b01:   count_nx_s = count_r - CNT_ONE;
      default: count_nx_s = count_r;
    endcase
  end

  assign idle_nx_s = (count_nx_s == {CW{1'b0}}) && (state_nx_s == ST_IDLE);

  // Circular write queue; push and pop never hit the same slot on one edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_r <= {DEPTH{1'b0}};
      head_r  <= {PW{1'b0}};
      tail_r  <= {PW{1'b0}};
      count_r <= {CW{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        q_addr_r[i] <= {AW{1'b0}};
        q_mask_r[i] <= {MW{1'b0}};
        q_data_r[i] <= {RV{1'b0}};
      end
    end else begin
      if (push_s) begin
        q_addr_r[tail_r] <= bus.c_waddr;
        q_mask_r[tail_r] <= bus.c_wmask;
        q_data_r[tail_r] <= bus.c_wdata;
        valid_r[tail_r]  <= 1'b1;
        tail_r           <= tail_r + PTR_ONE;
      end
      if (pop_s) begin
        valid_r[head_r] <= 1'b0;
        head_r          <= head_r + PTR_ONE;
      end
      count_r <= count_nx_s;
    end
  end

  // Downstream engine state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Output registers for both the cpu and adapter sides.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      c_wdone_r <= 1'b0;
      c_rdone_r <= 1'b0;
      c_rdata_r <= {RV{1'b0}};
      m_waddr_r <= {AW{1'b0}};
      m_wmask_r <= {MW{1'b0}};
      m_wdata_r <= {RV{1'b0}};
      m_raddr_r <= {AW{1'b0}};
      m_rreq_r  <= 2'b00;
      idle_r    <= 1'b1;
    end else begin
      c_wdone_r <= push_s;
      c_rdone_r <= c_rdone_nx_s;
      c_rdata_r <= c_rdata_nx_s;
      m_waddr_r <= m_waddr_nx_s;
      m_wmask_r <= m_wmask_nx_s;
      m_wdata_r <= m_wdata_nx_s;
      m_raddr_r <= m_raddr_nx_s;
      m_rreq_r  <= m_rreq_nx_s;
      idle_r    <= idle_nx_s;
    end
  end
endmodule

// File: tb/tb_mem_write_buffer.sv
// Self-checking bench for mem_write_buffer (RV=32, DEPTH=2).
// A queue-based reference model predicts every output each cycle; a table
// of directed cycles carries hand-derived expectations; short hand-written
// sequences cover pointer wrap and reset during a drain; a random phase
// exercises hazards, spurious done pulses and resets.
module tb_mem_write_buffer;
  localparam int RV    = 32;
  localparam int DEPTH = 2;
  localparam int AW    = RV - RV / 16;
  localparam int MW    = RV / 8;

  logic clk = 1'b0;
  logic rst_n;
  logic idle;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  mem_write_buffer_if #(.RV(RV)) bus ();

  mem_write_buffer #(.RV(RV), .DEPTH(DEPTH)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus),
    .idle (idle)
  );

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [AW-1:0] addr;
    logic [MW-1:0] mask;
    logic [RV-1:0] data;
  } ent_t;

  ent_t          mq[$];
  int            mode;          // 0 idle, 1 writing, 2 reading
  logic          exp_wdone, exp_rdone, exp_idle;
  logic [RV-1:0] exp_rdata, exp_mwdata;
  logic [AW-1:0] exp_mwaddr, exp_mraddr;
  logic [MW-1:0] exp_mwmask;
  logic [1:0]    exp_mrreq;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    logic acc, haz, nrdone;
    ent_t e;
    if (!rst_n) begin
      mq.delete();
      mode = 0;
      exp_wdone = 1'b0; exp_rdone = 1'b0; exp_mwmask = 4'h0; exp_mrreq = 2'b00; exp_idle = 1'b1;
      return;
    end
    acc = (bus.c_wmask != 4'h0) && (mq.size() < DEPTH) && !exp_wdone;
    haz = 1'b0;
    foreach (mq[i]) if (mq[i].addr == bus.c_raddr) haz = 1'b1;
    e.addr = bus.c_waddr; e.mask = bus.c_wmask; e.data = bus.c_wdata;
    nrdone = 1'b0;
    case (mode)
      0: begin
        if (bus.c_rreq != 2'b00 && !haz && !exp_rdone) begin
          mode = 2; exp_mraddr = bus.c_raddr; exp_mrreq = bus.c_rreq;
        end else if (mq.size() > 0 && (bus.c_rreq == 2'b00 || haz)) begin
          mode = 1; exp_mwaddr = mq[0].addr; exp_mwmask = mq[0].mask; exp_mwdata = mq[0].data;
        end
      end
      1: if (bus.m_wdone) begin void'(mq.pop_front()); exp_mwmask = 4'h0; mode = 0; end
      2: if (bus.m_rdone) begin exp_rdata = bus.m_rdata; nrdone = 1'b1; exp_mrreq = 2'b00; mode = 0; end
      default: mode = 0;
    endcase
    exp_rdone = nrdone;
    exp_wdone = acc;
    if (acc) mq.push_back(e);
    exp_idle = (mq.size() == 0) && (mode == 0);
  endtask

  task automatic model_check();
    chk("c_wdone", bus.c_wdone, exp_wdone);
    chk("c_rdone", bus.c_rdone, exp_rdone);
    chk("m_wmask", bus.m_wmask, exp_mwmask);
    chk("m_rreq", bus.m_rreq, exp_mrreq);
    chk("idle", idle, exp_idle);
    chk("mutex", (bus.m_wmask != 4'h0) && (bus.m_rreq != 2'b00), 1'b0);
    if (exp_mwmask != 4'h0) begin
      chk("m_waddr", bus.m_waddr, exp_mwaddr);
      chk("m_wdata", bus.m_wdata, exp_mwdata);
    end
    if (exp_mrreq != 2'b00) chk("m_raddr", bus.m_raddr, exp_mraddr);
    if (exp_rdone) chk("c_rdata", bus.c_rdata, exp_rdata);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    model_check();
  endtask

  task automatic drive(input logic [MW-1:0] wm, input logic [AW-1:0] wa, input logic [RV-1:0] wd,
                       input logic [1:0] rr, input logic [AW-1:0] ra,
                       input logic wdn, input logic rdn, input logic [RV-1:0] rdat);
    bus.c_wmask = wm; bus.c_waddr = wa; bus.c_wdata = wd;
    bus.c_rreq = rr; bus.c_raddr = ra;
    bus.m_wdone = wdn; bus.m_rdone = rdn; bus.m_rdata = rdat;
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic [MW-1:0] wm; logic [AW-1:0] wa; logic [RV-1:0] wd;
    logic [1:0] rr; logic [AW-1:0] ra; logic wdn; logic rdn; logic [RV-1:0] rdat;
    logic ewd; logic erd; logic [MW-1:0] emw; logic [AW-1:0] ewa; logic [RV-1:0] ewdat;
    logic [1:0] err; logic [RV-1:0] erdat; logic eidle;
  } vec_t;

  vec_t tbl[$];

  task automatic row(input logic [MW-1:0] wm, input logic [AW-1:0] wa, input logic [RV-1:0] wd,
                     input logic [1:0] rr, input logic [AW-1:0] ra, input logic wdn, input logic rdn,
                     input logic [RV-1:0] rdat, input logic ewd, input logic erd,
                     input logic [MW-1:0] emw, input logic [AW-1:0] ewa, input logic [RV-1:0] ewdat,
                     input logic [1:0] err, input logic [RV-1:0] erdat, input logic eidle);
    vec_t v;
    v.wm = wm; v.wa = wa; v.wd = wd; v.rr = rr; v.ra = ra; v.wdn = wdn; v.rdn = rdn; v.rdat = rdat;
    v.ewd = ewd; v.erd = erd; v.emw = emw; v.ewa = ewa; v.ewdat = ewdat;
    v.err = err; v.erdat = erdat; v.eidle = eidle;
    tbl.push_back(v);
  endtask

  initial begin
    logic [AW-1:0] a;
    logic [RV-1:0] d;

    rst_n = 1'b0;
    drive(4'h0, 30'h0, 32'h0, 2'b00, 30'h0, 1'b0, 1'b0, 32'h0);
    cycle();
    cycle();
    chk("reset_idle", idle, 1'b1);
    chk("reset_wmask", bus.m_wmask, 4'h0);
    chk("reset_rreq", bus.m_rreq, 2'b00);
    rst_n = 1'b1;

    // single write at 0x40
    row(4'hF, 30'h40, 32'h1234, 2'b00, 30'h0, 1'b0, 1'b0, 32'h0,  1'b1, 1'b0, 4'h0, 30'h0,  32'h0,    2'b00, 32'h0, 1'b0);
    row(4'h0, 30'h0,  32'h0,    2'b00, 30'h0, 1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 4'hF, 30'h40, 32'h1234, 2'b00, 32'h0, 1'b0);
    row(4'h0, 30'h0,  32'h0,    2'b00, 30'h0, 1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 4'hF, 30'h40, 32'h1234, 2'b00, 32'h0, 1'b0);
    row(4'h0, 30'h0,  32'h0,    2'b00, 30'h0, 1'b1, 1'b0, 32'h0,  1'b0, 1'b0, 4'h0, 30'h0,  32'h0,    2'b00, 32'h0, 1'b1);
    row(4'h0, 30'h0,  32'h0,    2'b00, 30'h0, 1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 4'h0, 30'h0,  32'h0,    2'b00, 32'h0, 1'b1);
    // three writes with a stalled adapter; third waits for a free slot
    row(4'hF, 30'h1, 32'h11111111, 2'b00, 30'h0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 4'h0, 30'h0, 32'h0,        2'b00, 32'h0, 1'b0);
    row(4'hF, 30'h2, 32'h22222222, 2'b00, 30'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 4'hF, 30'h1, 32'h11111111, 2'b00, 32'h0, 1'b0);
    row(4'hF, 30'h2, 32'h22222222, 2'b00, 30'h0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 4'hF, 30'h1, 32'h11111111, 2'b00, 32'h0, 1'b0);
    row(4'hF, 30'h3, 32'h33333333, 2'b00, 30'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 4'hF, 30'h1, 32'h11111111, 2'b00, 32'h0, 1'b0);
    row(4'hF, 30'h3, 32'h33333333, 2'b00, 30'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 4'hF, 30'h1, 32'h11111111, 2'b00, 32'h0, 1'b0);
    row(4'hF, 30'h3, 32'h33333333, 2'b00, 30'h0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 30'h0, 32'h0,        2'b00, 32'h0, 1'b0);
    row(4'hF, 30'h3, 32'h33333333, 2'b00, 30'h0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 4'hF, 30'h2, 32'h22222222, 2'b00, 32'h0, 1'b0);
    row(4'h0, 30'h0, 32'h0,        2'b00, 30'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 4'hF, 30'h2, 32'h22222222, 2'b00, 32'h0, 1'b0);
    row(4'h0, 30'h0, 32'h0,        2'b00, 30'h0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 30'h0, 32'h0,        2'b00, 32'h0, 1'b0);
    row(4'h0, 30'h0, 32'h0,        2'b00, 30'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 4'hF, 30'h3, 32'h33333333, 2'b00, 32'h0, 1'b0);
    row(4'h0, 30'h0, 32'h0,        2'b00, 30'h0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 30'h0, 32'h0,        2'b00, 32'h0, 1'b1);
    // read to a queued word waits for the drain
    row(4'hF, 30'h80, 32'h55, 2'b00, 30'h0,  1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 4'h0, 30'h0,  32'h0,  2'b00, 32'h0,        1'b0);
    row(4'h0, 30'h0,  32'h0,  2'b11, 30'h80, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 4'hF, 30'h80, 32'h55, 2'b00, 32'h0,        1'b0);
    row(4'h0, 30'h0,  32'h0,  2'b11, 30'h80, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 4'hF, 30'h80, 32'h55, 2'b00, 32'h0,        1'b0);
    row(4'h0, 30'h0,  32'h0,  2'b11, 30'h80, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 4'h0, 30'h0,  32'h0,  2'b00, 32'h0,        1'b1);
    row(4'h0, 30'h0,  32'h0,  2'b11, 30'h80, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 4'h0, 30'h0,  32'h0,  2'b11, 32'h0,        1'b0);
    row(4'h0, 30'h0,  32'h0,  2'b11, 30'h80, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0, 1'b1, 4'h0, 30'h0,  32'h0,  2'b00, 32'hDEADBEEF, 1'b1);
    row(4'h0, 30'h0,  32'h0,  2'b00, 30'h0,  1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 4'h0, 30'h0,  32'h0,  2'b00, 32'h0,        1'b1);
    // read to a different word overtakes the queued write
    row(4'hF, 30'h80, 32'h77, 2'b00, 30'h0,  1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 4'h0, 30'h0,  32'h0,  2'b00, 32'h0,        1'b0);
    row(4'h0, 30'h0,  32'h0,  2'b11, 30'h84, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 4'h0, 30'h0,  32'h0,  2'b11, 32'h0,        1'b0);
    row(4'h0, 30'h0,  32'h0,  2'b11, 30'h84, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 4'h0, 30'h0,  32'h0,  2'b11, 32'h0,        1'b0);
    row(4'h0, 30'h0,  32'h0,  2'b11, 30'h84, 1'b0, 1'b1, 32'h12345678, 1'b0, 1'b1, 4'h0, 30'h0,  32'h0,  2'b00, 32'h12345678, 1'b0);
    row(4'h0, 30'h0,  32'h0,  2'b00, 30'h0,  1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 4'hF, 30'h80, 32'h77, 2'b00, 32'h0,        1'b0);
    row(4'h0, 30'h0,  32'h0,  2'b00, 30'h0,  1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 4'h0, 30'h0,  32'h0,  2'b00, 32'h0,        1'b1);

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].wm, tbl[i].wa, tbl[i].wd, tbl[i].rr, tbl[i].ra, tbl[i].wdn, tbl[i].rdn, tbl[i].rdat);
      cycle();
      chk($sformatf("r%0d_wdone", i), bus.c_wdone, tbl[i].ewd);
      chk($sformatf("r%0d_rdone", i), bus.c_rdone, tbl[i].erd);
      chk($sformatf("r%0d_mwmask", i), bus.m_wmask, tbl[i].emw);
      chk($sformatf("r%0d_mrreq", i), bus.m_rreq, tbl[i].err);
      chk($sformatf("r%0d_idle", i), idle, tbl[i].eidle);
      if (tbl[i].emw != 4'h0) begin
        chk($sformatf("r%0d_mwaddr", i), bus.m_waddr, tbl[i].ewa);
        chk($sformatf("r%0d_mwdata", i), bus.m_wdata, tbl[i].ewdat);
      end
      if (tbl[i].erd) chk($sformatf("r%0d_rdata", i), bus.c_rdata, tbl[i].erdat);
    end

    // push and pop on one edge at count=1, wrapping the pointers several times
    drive(4'hF, 30'h100, 32'hA5000000, 2'b00, 30'h0, 1'b0, 1'b0, 32'h0);
    cycle();
    chk("wrap_first_wdone", bus.c_wdone, 1'b1);
    drive(4'h0, 30'h0, 32'h0, 2'b00, 30'h0, 1'b0, 1'b0, 32'h0);
    cycle();
    chk("wrap_first_addr", bus.m_waddr, 30'h100);
    for (int k = 1; k <= 2 * DEPTH + 1; k++) begin
      a = 30'h100 + 30'(k);
      d = 32'hA5000000 + 32'(k);
      drive(4'hF, a, d, 2'b00, 30'h0, 1'b1, 1'b0, 32'h0);
      cycle();
      chk("wrap_wdone", bus.c_wdone, 1'b1);
      chk("wrap_wmask_gap", bus.m_wmask, 4'h0);
      drive(4'h0, 30'h0, 32'h0, 2'b00, 30'h0, 1'b0, 1'b0, 32'h0);
      cycle();
      chk("wrap_wmask", bus.m_wmask, 4'hF);
      chk("wrap_addr", bus.m_waddr, a);
      chk("wrap_data", bus.m_wdata, d);
    end
    drive(4'h0, 30'h0, 32'h0, 2'b00, 30'h0, 1'b1, 1'b0, 32'h0);
    cycle();
    chk("wrap_idle", idle, 1'b1);

    // reset while writing with a full queue
    drive(4'hF, 30'h200, 32'hC0DE0001, 2'b00, 30'h0, 1'b0, 1'b0, 32'h0);
    cycle();
    drive(4'h0, 30'h0, 32'h0, 2'b00, 30'h0, 1'b0, 1'b0, 32'h0);
    cycle();
    drive(4'hF, 30'h201, 32'hC0DE0002, 2'b00, 30'h0, 1'b0, 1'b0, 32'h0);
    cycle();
    drive(4'h0, 30'h0, 32'h0, 2'b00, 30'h0, 1'b0, 1'b0, 32'h0);
    cycle();
    chk("rst_pre_wmask", bus.m_wmask, 4'hF);
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    chk("rst_wdone", bus.c_wdone, 1'b0);
    chk("rst_rdone", bus.c_rdone, 1'b0);
    chk("rst_wmask", bus.m_wmask, 4'h0);
    chk("rst_rreq", bus.m_rreq, 2'b00);
    chk("rst_idle", idle, 1'b1);
    for (int k = 0; k < 5; k++) begin
      drive(4'h0, 30'h0, 32'h0, 2'b00, 30'h0, k[0], 1'b0, 32'h0);
      cycle();
      chk("rst_post_wmask", bus.m_wmask, 4'h0);
      chk("rst_post_idle", idle, 1'b1);
    end

    // randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      drive(($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom),
            30'h10 + 30'($urandom_range(0, 3)), $urandom,
            ($urandom_range(0, 2) == 0) ? 2'($urandom) : 2'b00,
            30'h10 + 30'($urandom_range(0, 3)),
            ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0), $urandom);
      rst_n = ($urandom_range(0, 299) != 0);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
